// File: rtl/mmu_walk_port.sv
// mmu_walk_port: responder for the MMU page-walk fetch port.
// Each MMU read (ren/addr) becomes one Wishbone read cycle. The returned entry comes back
// with a one-cycle ack pulse. Bus errors and timeouts return a not-present entry (all zero).
// Optional feature macro: MMU_WALK_PDE_CACHE_EN adds a single-entry cache of the last
// fetched PDE (returned data[0]=1). With the cache, a hit acks without a bus cycle.
module mmu_walk_port #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        suspend,
  input  logic        flush,
  input  logic        ren,
  input  logic [31:0] addr,
  output logic        ack,
  output logic [31:0] data,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic [29:0] wb_addr,
  input  logic        wb_ack,
  input  logic        wb_err,
  input  logic [31:0] wb_din
);

  typedef enum logic [1:0] {StIdle, StBus, StAck, StGap} state_e;

  localparam bit         TimeoutEn   = (TIMEOUT != 0);
  localparam logic [7:0] TimeoutLast = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] data_q, data_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic [29:0] wb_addr_q, wb_addr_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        hit;
  logic [31:0] hit_data;
  logic        cache_fill;

`ifdef MMU_WALK_PDE_CACHE_EN
  logic        cache_valid_q, cache_valid_d;
  logic [29:0] cache_addr_q, cache_addr_d;
  logic [31:0] cache_data_q, cache_data_d;
  logic        unused_ok;

  assign hit       = cache_valid_q && (cache_addr_q == addr[31:2]);
  assign hit_data  = cache_data_q;
  assign unused_ok = ^addr[1:0];

  // Cache next state: fill on a successful PDE fetch, invalidate on flush or abort.
  always_comb begin
    cache_valid_d = cache_valid_q;
    cache_addr_d  = cache_addr_q;
    cache_data_d  = cache_data_q;
    if (cache_fill) begin
      cache_valid_d = 1'b1;
      cache_addr_d  = wb_addr_q;
      cache_data_d  = wb_din;
    end
    // Invalidation wins over a fill in the same cycle.
    if (flush || suspend) begin
      cache_valid_d = 1'b0;
    end
  end

  // Cache registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid_q <= 1'b0;
      cache_addr_q  <= '0;
      cache_data_q  <= '0;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_addr_q  <= cache_addr_d;
      cache_data_q  <= cache_data_d;
    end
  end
`else
  logic unused_ok;

  assign hit       = 1'b0;
  assign hit_data  = '0;
  assign unused_ok = ^{addr[1:0], flush, cache_fill};
`endif

  // Request FSM: next state and registered outputs.
  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    data_d     = data_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    wb_addr_d  = wb_addr_q;
    cnt_d      = cnt_q;
    cache_fill = 1'b0;
    if (suspend) begin
      // Abort: drop the bus cycle, discard any response and issue no ack.
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      cnt_d   = '0;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ren) begin
            if (hit) begin
              data_d  = hit_data;
              ack_d   = 1'b1;
              state_d = StAck;
            end else begin
              wb_addr_d = addr[31:2];
              cyc_d     = 1'b1;
              stb_d     = 1'b1;
              cnt_d     = '0;
              state_d   = StBus;
            end
          end
        end
        StBus: begin
          if (wb_ack) begin
            data_d     = wb_din;
            ack_d      = 1'b1;
            cyc_d      = 1'b0;
            stb_d      = 1'b0;
            cache_fill = wb_din[0];
            state_d    = StAck;
          end else if (wb_err || (TimeoutEn && (cnt_q == TimeoutLast))) begin
            // Not-present entry makes the MMU fault instead of hanging.
            data_d  = '0;
            ack_d   = 1'b1;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            state_d = StAck;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StAck: state_d = StGap;
        // The MMU holds ren with a stale address for one cycle after its final ack.
        StGap: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ack_q     <= 1'b0;
      data_q    <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      wb_addr_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      data_q    <= data_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      wb_addr_q <= wb_addr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ack     = ack_q;
  assign data    = data_q;
  assign wb_cyc  = cyc_q;
  assign wb_stb  = stb_q;
  assign wb_addr = wb_addr_q;

endmodule

// File: tb/tb_mmu_walk_port.sv
// Bench for mmu_walk_port: scoreboard of expected {data, ack edge} against observed acks.
module tb_mmu_walk_port;

  localparam int unsigned TbTimeout = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        suspend = 1'b0;
  logic        flush = 1'b0;
  logic        ren = 1'b0;
  logic [31:0] addr = '0;
  logic        ack;
  logic [31:0] data;
  logic        wb_cyc;
  logic        wb_stb;
  logic [29:0] wb_addr;
  logic        wb_ack = 1'b0;
  logic        wb_err = 1'b0;
  logic [31:0] wb_din = '0;

  mmu_walk_port #(.TIMEOUT(TbTimeout)) dut (
    .clk(clk), .rst(rst), .suspend(suspend), .flush(flush), .ren(ren), .addr(addr),
    .ack(ack), .data(data), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_addr(wb_addr),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_din(wb_din)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          at;
  } ack_t;

  int          total = 0;
  int          bad = 0;
  int          cyc_n = 0;
  int          proto_err = 0;
  ack_t        exp_q[$];
  ack_t        obs_q[$];
  logic [29:0] bus_q[$];
  logic        cyc_prev = 1'b0;
  logic [29:0] addr_prev = '0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Monitor: record acks with their edge number, bus cycle starts, and protocol slips.
  always @(negedge clk) begin
    ack_t o;
    if (ack === 1'b1) begin
      o.d = data;
      o.at = cyc_n;
      obs_q.push_back(o);
    end
    if (wb_cyc === 1'b1 && cyc_prev !== 1'b1) bus_q.push_back(wb_addr);
    if (wb_stb !== wb_cyc) proto_err++;
    if (wb_cyc === 1'b1 && cyc_prev === 1'b1 && wb_addr !== addr_prev) proto_err++;
    cyc_prev = wb_cyc;
    addr_prev = wb_addr;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang want finish");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_q();
    exp_q.delete();
    obs_q.delete();
    bus_q.delete();
  endtask

  // Pops one expected/observed pair; a missing observation reads as x data at edge -1.
  task automatic take(output ack_t e, output ack_t o);
    e.d = 'x;
    e.at = -2;
    o.d = 'x;
    o.at = -1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    if (obs_q.size() > 0) o = obs_q.pop_front();
  endtask

  // Bus slave: respond on wait cycle `waits`. mode 0=ack 1=err 2=ack+err 3=never.
  task automatic serve(input int waits, input int mode, input logic [31:0] din,
                       output int cyc_len);
    int k;
    k = 0;
    cyc_len = 0;
    wb_din = din;
    while (wb_cyc === 1'b1 && cyc_len < 300) begin
      if (k == waits && mode != 3) begin
        wb_ack = (mode != 1);
        wb_err = (mode != 0);
      end else begin
        wb_ack = 1'b0;
        wb_err = 1'b0;
      end
      step();
      k++;
      cyc_len++;
    end
    wb_ack = 1'b0;
    wb_err = 1'b0;
  endtask

  // One MMU fetch; lat is ack edge minus ren-sample edge (0 means a cache hit, no bus).
  task automatic fetch(input logic [31:0] a, input int waits, input int mode,
                       input logic [31:0] din, input logic [31:0] exp_d, input int lat,
                       output int cyc_len);
    ack_t e;
    addr = a;
    ren = 1'b1;
    wb_din = (lat == 0) ? 32'hBAD0_BAD0 : din;
    e.d = exp_d;
    e.at = cyc_n + 1 + lat;
    exp_q.push_back(e);
    step();
    ren = 1'b0;
    cyc_len = 0;
    if (lat != 0) serve(waits, mode, din, cyc_len);
    step();
    step();
  endtask

  task automatic test_reset();
    #1;
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset ack: got %b want 0", ack); end
    total++; if (data !== 32'h0) begin bad++; $display("FAIL reset data: got %h want 0", data); end
    total++; if (wb_cyc !== 1'b0) begin bad++; $display("FAIL reset cyc: got %b want 0", wb_cyc); end
    total++; if (wb_stb !== 1'b0) begin bad++; $display("FAIL reset stb: got %b want 0", wb_stb); end
    total++; if (wb_addr !== 30'h0) begin bad++; $display("FAIL reset wb_addr: got %h want 0", wb_addr); end
    step();
    rst = 1'b0;
    step();
    clear_q();
  endtask

  task automatic test_single();
    ack_t e, o;
    int len;
    clear_q();
    fetch(32'h0010_0804, 0, 0, 32'h0020_001F, 32'h0020_001F, 1, len);
    take(e, o);
    total++; if (o.d !== e.d) begin bad++; $display("FAIL single data: got %h want %h", o.d, e.d); end
    total++; if (o.at != e.at) begin bad++; $display("FAIL single ack edge: got %0d want %0d", o.at, e.at); end
    total++; if (len != 1) begin bad++; $display("FAIL single cyc len: got %0d want 1", len); end
    total++; if (bus_q.size() != 1 || bus_q[0] !== 30'h0004_0201) begin
      bad++; $display("FAIL single wb_addr: got %0d cycles first %h want 1 cycle 00040201",
                      bus_q.size(), (bus_q.size() > 0) ? bus_q[0] : 30'h0);
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL single extra acks: got %0d want 0", obs_q.size()); end
  endtask

  task automatic test_walk();
    ack_t e, o;
    int len1, len2;
    clear_q();
    addr = 32'h0000_2000;
    ren = 1'b1;
    e.d = 32'h0030_0001; e.at = cyc_n + 2; exp_q.push_back(e);
    step();
    serve(0, 0, 32'h0030_0001, len1);
    // MMU retargets to the PTE while ren stays high; IDLE samples it 3 edges after the ack.
    addr = 32'h0030_0010;
    e.d = 32'h0040_0017; e.at = cyc_n + 3 + 2; exp_q.push_back(e);
    step(); step(); step();
    serve(1, 0, 32'h0040_0017, len2);
    step(); step();
    ren = 1'b0;
    repeat (5) step();
    for (int i = 0; i < 2; i++) begin
      take(e, o);
      total++; if (o.d !== e.d) begin bad++; $display("FAIL walk data %0d: got %h want %h", i, o.d, e.d); end
      total++; if (o.at != e.at) begin bad++; $display("FAIL walk ack edge %0d: got %0d want %0d", i, o.at, e.at); end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL walk extra acks: got %0d want 0", obs_q.size()); end
    total++; if (len1 != 1 || len2 != 2) begin bad++; $display("FAIL walk cyc lens: got %0d,%0d want 1,2", len1, len2); end
    total++; if (bus_q.size() != 2) begin bad++; $display("FAIL walk bus cycles: got %0d want 2", bus_q.size()); end
    else begin
      total++; if (bus_q[0] !== 30'h0000_0800 || bus_q[1] !== 30'h000C_0004) begin
        bad++; $display("FAIL walk addrs: got %h,%h want 00000800,000c0004", bus_q[0], bus_q[1]);
      end
    end
  endtask

  task automatic test_error_timeout();
    ack_t e, o;
    int len_err, len_both, len_to;
    clear_q();
    fetch(32'h0000_3000, 3, 1, 32'hDEAD_BEEF, 32'h0, 4, len_err);
    fetch(32'h0000_5000, 1, 2, 32'h0000_0005, 32'h5, 2, len_both);
    fetch(32'h0000_4000, 0, 3, 32'hFFFF_FFFF, 32'h0, TbTimeout, len_to);
    for (int i = 0; i < 3; i++) begin
      take(e, o);
      total++; if (o.d !== e.d) begin bad++; $display("FAIL errto data %0d: got %h want %h", i, o.d, e.d); end
      total++; if (o.at != e.at) begin bad++; $display("FAIL errto ack edge %0d: got %0d want %0d", i, o.at, e.at); end
    end
    total++; if (len_err != 4) begin bad++; $display("FAIL err cyc len: got %0d want 4", len_err); end
    total++; if (len_both != 2) begin bad++; $display("FAIL both cyc len: got %0d want 2", len_both); end
    total++; if (len_to != TbTimeout) begin bad++; $display("FAIL timeout cyc len: got %0d want %0d", len_to, TbTimeout); end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL errto extra acks: got %0d want 0", obs_q.size()); end
  endtask

  task automatic test_abort();
    ack_t e, o;
    int len;
    clear_q();
    addr = 32'h0000_6000;
    ren = 1'b1;
    step();
    ren = 1'b0;
    suspend = 1'b1;
    wb_ack = 1'b1;
    wb_din = 32'h0000_1234;
    step();
    suspend = 1'b0;
    wb_ack = 1'b0;
    total++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin
      bad++; $display("FAIL abort cyc/stb: got %b/%b want 0/0", wb_cyc, wb_stb);
    end
    repeat (3) step();
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL abort acks: got %0d want 0", obs_q.size()); end
    fetch(32'h0000_7000, 0, 0, 32'h0000_ABCD, 32'h0000_ABCD, 1, len);
    take(e, o);
    total++; if (o.d !== e.d) begin bad++; $display("FAIL abort next data: got %h want %h", o.d, e.d); end
    total++; if (o.at != e.at) begin bad++; $display("FAIL abort next edge: got %0d want %0d", o.at, e.at); end
    total++; if (bus_q.size() != 2 || bus_q[1] !== 30'h0000_1C00) begin
      bad++; $display("FAIL abort bus cycles: got %0d want 2 ending 00001c00", bus_q.size());
    end
  endtask

  task automatic test_rst_mid();
    clear_q();
    addr = 32'h0000_8000;
    ren = 1'b1;
    step();
    ren = 1'b0;
    total++; if (wb_cyc !== 1'b1) begin bad++; $display("FAIL rstmid pre cyc: got %b want 1", wb_cyc); end
    rst = 1'b1;
    #1;
    total++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin
      bad++; $display("FAIL rstmid cyc/stb: got %b/%b want 0/0", wb_cyc, wb_stb);
    end
    total++; if (wb_addr !== 30'h0) begin bad++; $display("FAIL rstmid wb_addr: got %h want 0", wb_addr); end
    total++; if (data !== 32'h0 || ack !== 1'b0) begin
      bad++; $display("FAIL rstmid data/ack: got %h/%b want 0/0", data, ack);
    end
    step();
    rst = 1'b0;
    repeat (3) step();
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rstmid acks: got %0d want 0", obs_q.size()); end
  endtask

`ifdef MMU_WALK_PDE_CACHE_EN
  task automatic test_cache();
    ack_t e, o;
    int len;
    clear_q();
    fetch(32'h0000_1000, 0, 0, 32'h0050_0001, 32'h0050_0001, 1, len);
    fetch(32'h0000_3000, 0, 0, 32'h0000_0002, 32'h0000_0002, 1, len);
    fetch(32'h0000_1000, 0, 0, 32'h0, 32'h0050_0001, 0, len);
    total++; if (bus_q.size() != 2) begin bad++; $display("FAIL cache hit bus: got %0d cycles want 2", bus_q.size()); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    fetch(32'h0000_1000, 0, 0, 32'h0050_0001, 32'h0050_0001, 1, len);
    fetch(32'h0000_2000, 0, 0, 32'h0060_0000, 32'h0060_0000, 1, len);
    fetch(32'h0000_2000, 0, 0, 32'h0060_0000, 32'h0060_0000, 1, len);
    total++; if (bus_q.size() != 5) begin bad++; $display("FAIL cache miss bus: got %0d cycles want 5", bus_q.size()); end
    for (int i = 0; i < 6; i++) begin
      take(e, o);
      total++; if (o.d !== e.d) begin bad++; $display("FAIL cache data %0d: got %h want %h", i, o.d, e.d); end
      total++; if (o.at != e.at) begin bad++; $display("FAIL cache edge %0d: got %0d want %0d", i, o.at, e.at); end
    end
  endtask
`else
  task automatic test_no_cache();
    ack_t e, o;
    int len;
    clear_q();
    fetch(32'h0000_1000, 0, 0, 32'h0050_0001, 32'h0050_0001, 1, len);
    fetch(32'h0000_1000, 0, 0, 32'h0050_0003, 32'h0050_0003, 1, len);
    flush = 1'b1;
    step();
    flush = 1'b0;
    fetch(32'h0000_1000, 0, 0, 32'h0050_0005, 32'h0050_0005, 1, len);
    total++; if (bus_q.size() != 3) begin bad++; $display("FAIL nocache bus: got %0d cycles want 3", bus_q.size()); end
    for (int i = 0; i < 3; i++) begin
      take(e, o);
      total++; if (o.d !== e.d) begin bad++; $display("FAIL nocache data %0d: got %h want %h", i, o.d, e.d); end
      total++; if (o.at != e.at) begin bad++; $display("FAIL nocache edge %0d: got %0d want %0d", i, o.at, e.at); end
    end
  endtask
`endif

  task automatic test_protocol();
    total++; if (proto_err != 0) begin
      bad++; $display("FAIL protocol stb/addr slips: got %0d want 0", proto_err);
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL protocol stray acks: got %0d want 0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_walk();
    test_error_timeout();
    test_abort();
    test_rst_mid();
`ifdef MMU_WALK_PDE_CACHE_EN
    test_cache();
`else
    test_no_cache();
`endif
    repeat (2) step();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
